// File: rtl/msx_mouse_reader.sv
// MSX-side initiator for the joystick-port mouse nibble protocol: toggles the strobe,
// samples four nibbles and presents the assembled X/Y deltas and button bits.
module msx_mouse_reader #(
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned POLL_CYC   = 567500
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic       poll_now,
    input  logic [5:0] joy_in,
    output logic       strobe_out,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned PW = $clog2(POLL_CYC);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StToggle,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e          state;
    logic [5:0]      joy_m;
    logic [5:0]      joy_s;
    logic [PW-1:0]   poll_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      idx;
    logic [1:0]      btn_cap;
    logic [3:0]      nib [4];

    // Port pins are asynchronous; idle level is all-high.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_m <= 6'h3F;
            joy_s <= 6'h3F;
        end else begin
            joy_m <= joy_in;
            joy_s <= joy_m;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= StIdle;
            strobe_out <= 1'b0;
            dx         <= 8'h00;
            dy         <= 8'h00;
            buttons    <= 2'b00;
            valid      <= 1'b0;
            busy       <= 1'b0;
            poll_cnt   <= '0;
            settle_cnt <= '0;
            idx        <= 2'd0;
            btn_cap    <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                nib[i] <= 4'h0;
            end
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                // Abort leaves the strobe at its current level; the responder re-aligns
                // through its idle timeout before the next frame.
                state    <= StIdle;
                busy     <= 1'b0;
                idx      <= 2'd0;
                poll_cnt <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (poll_now || poll_cnt == POLL_LAST) begin
                            poll_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= StToggle;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                        end
                    end
                    StToggle: begin
                        strobe_out <= ~strobe_out;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= StSettle;
                    end
                    StSettle: begin
                        if (settle_cnt == '0) begin
                            state <= StSample;
                        end else begin
                            settle_cnt <= settle_cnt - SW'(1);
                        end
                    end
                    StSample: begin
                        nib[idx] <= joy_s[3:0];
                        if (idx == 2'd3) begin
                            btn_cap <= ~joy_s[5:4];
                            state   <= StDone;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= StToggle;
                        end
                    end
                    StDone: begin
                        dx      <= {nib[0], nib[1]};
                        dy      <= {nib[2], nib[3]};
                        buttons <= btn_cap;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        idx     <= 2'd0;
                        state   <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Loopback bench: a behavioural nibble responder drives joy_in, a scoreboard queue
// holds the frame each stimulus should produce and is checked on every valid pulse.
module tb_msx_mouse_reader;

    localparam int unsigned SETTLE       = 4;
    localparam int unsigned POLL         = 200;
    localparam int          RESP_TIMEOUT = 150;

    typedef struct packed {
        logic [7:0] dx;
        logic [7:0] dy;
        logic [1:0] btn;
    } frame_t;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       enable;
    logic       poll_now;
    logic [5:0] joy_in;
    logic       strobe_out;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] buttons;
    logic       valid;
    logic       busy;

    always #5 clk_sys = ~clk_sys;

    msx_mouse_reader #(
        .SETTLE_CYC (SETTLE),
        .POLL_CYC   (POLL)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .enable     (enable),
        .poll_now   (poll_now),
        .joy_in     (joy_in),
        .strobe_out (strobe_out),
        .dx         (dx),
        .dy         (dy),
        .buttons    (buttons),
        .valid      (valid),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Responder model: one nibble per strobe edge, index cleared after an idle timeout.
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [1:0] r_btn;
    logic [3:0] r_nib = 4'hF;
    logic [1:0] r_idx;
    logic       r_prev;
    int         r_idle;
    logic       use_resp;
    logic [5:0] static_joy;

    function automatic logic [3:0] resp_nibble(input logic [1:0] i, input logic [7:0] x,
                                               input logic [7:0] y);
        case (i)
            2'd0:    return x[7:4];
            2'd1:    return x[3:0];
            2'd2:    return y[7:4];
            default: return y[3:0];
        endcase
    endfunction

    always @(posedge clk_sys) begin
        if (reset) begin
            r_idx  <= 2'd0;
            r_prev <= 1'b0;
            r_idle <= 0;
        end else if (strobe_out != r_prev) begin
            r_prev <= strobe_out;
            r_nib  <= resp_nibble(r_idx, r_x, r_y);
            r_idx  <= r_idx + 2'd1;
            r_idle <= 0;
        end else if (r_idle >= RESP_TIMEOUT) begin
            r_idx <= 2'd0;
        end else begin
            r_idle <= r_idle + 1;
        end
    end

    assign joy_in = use_resp ? {r_btn, r_nib} : static_joy;

    // Output monitor and scoreboard.
    frame_t exp_q[$];
    frame_t last_exp = '0;
    int     edge_q[$];
    int     n_edges = 0;
    int     n_valid = 0;
    int     last_valid_cyc = 0;
    logic   mon_prev = 1'b0;

    always @(negedge clk_sys) begin
        frame_t e;
        if (strobe_out !== mon_prev) begin
            n_edges++;
            edge_q.push_back(cyc);
        end
        mon_prev = strobe_out;
        if (valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'b0, valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_dx", {24'b0, dx}, {24'b0, e.dx});
                check("frame_dy", {24'b0, dy}, {24'b0, e.dy});
                check("frame_buttons", {30'b0, buttons}, {30'b0, e.btn});
                last_exp = e;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int target, input int budget);
        int k = 0;
        while (n_valid < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, n_valid, target);
    endtask

    // Raises enable together with poll_now, so the frame starts in cycle c0.
    task automatic start_poll(output int c0);
        enable   = 1'b1;
        poll_now = 1'b1;
        c0       = cyc;
        tick(1);
        poll_now = 1'b0;
    endtask

    initial begin
        int   c0;
        int   r0;
        int   eb;
        int   e0;
        int   v0;
        logic s_hold;

        reset      = 1'b1;
        enable     = 1'b0;
        poll_now   = 1'b0;
        use_resp   = 1'b1;
        r_x        = 8'h00;
        r_y        = 8'h00;
        r_btn      = 2'b11;
        static_joy = 6'h3F;
        tick(3);

        check("rst_strobe", {31'b0, strobe_out}, 32'd0);
        check("rst_dx", {24'b0, dx}, 32'd0);
        check("rst_dy", {24'b0, dy}, 32'd0);
        check("rst_buttons", {30'b0, buttons}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Loopback x=+3 (FD on the wire), y=05, buttons released.
        r_x = 8'hFD;
        r_y = 8'h05;
        r_btn = 2'b11;
        eb = edge_q.size();
        v0 = n_valid;
        s_hold = strobe_out;
        exp_q.push_back(frame_t'({8'hFD, 8'h05, 2'b00}));
        start_poll(c0);
        check("loop_busy", {31'b0, busy}, 32'd1);
        wait_valid("loop_valid", v0 + 1, 60);
        check("loop_edges", edge_q.size() - eb, 4);
        for (int k = 0; k < 4; k++) begin
            check("loop_edge_time", edge_q[eb+k], c0 + 2 + 6 * k);
        end
        // valid is registered at the edge ending cycle T+25, seen in cycle T+26.
        check("loop_valid_time", last_valid_cyc, c0 + 26);
        check("loop_strobe_level", {31'b0, strobe_out}, {31'b0, s_hold});
        check("loop_busy_done", {31'b0, busy}, 32'd0);
        enable = 1'b0;
        tick(2);

        // Static pins, left button pressed.
        use_resp = 1'b0;
        static_joy = 6'b10_1010;
        tick(3);
        v0 = n_valid;
        exp_q.push_back(frame_t'({8'hAA, 8'hAA, 2'b01}));
        start_poll(c0);
        wait_valid("static_valid", v0 + 1, 60);
        tick(20);
        check("static_single_valid", n_valid, v0 + 1);
        enable = 1'b0;
        use_resp = 1'b1;
        tick(2);

        // Automatic polling straight out of reset.
        r_x = 8'h81;
        r_y = 8'h7E;
        r_btn = 2'b00;
        reset = 1'b1;
        enable = 1'b1;
        tick(2);
        eb = edge_q.size();
        v0 = n_valid;
        exp_q.push_back(frame_t'({8'h81, 8'h7E, 2'b11}));
        exp_q.push_back(frame_t'({8'h81, 8'h7E, 2'b11}));
        reset = 1'b0;
        r0 = cyc;
        wait_valid("auto_valid1", v0 + 1, 260);
        check("auto_edge1_time", edge_q[eb], r0 + 201);
        check("auto_valid1_time", last_valid_cyc, r0 + 225);
        wait_valid("auto_valid2", v0 + 2, 260);
        check("auto_edge2_time", edge_q[eb+4], r0 + 426);
        check("auto_valid2_time", last_valid_cyc, r0 + 450);
        enable = 1'b0;
        e0 = n_edges;
        tick(1000);
        check("disabled_no_edges", n_edges - e0, 0);

        // poll_now held during a frame, then coinciding with the counter wrap.
        r_x = 8'h12;
        r_y = 8'h34;
        r_btn = 2'b10;
        e0 = n_edges;
        eb = edge_q.size();
        v0 = n_valid;
        exp_q.push_back(frame_t'({8'h12, 8'h34, 2'b01}));
        start_poll(c0);
        tick(2);
        poll_now = 1'b1;
        tick(17);
        poll_now = 1'b0;
        wait_valid("hold_valid", v0 + 1, 40);
        check("hold_valid_time", last_valid_cyc, c0 + 26);
        tick(c0 + 225 - cyc);
        check("hold_no_extra_frame", n_edges - e0, 4);
        exp_q.push_back(frame_t'({8'h12, 8'h34, 2'b01}));
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
        wait_valid("wrap_valid", v0 + 2, 40);
        check("wrap_edge_time", edge_q[eb+4], c0 + 227);
        check("wrap_valid_time", last_valid_cyc, c0 + 251);
        check("wrap_single_frame", n_edges - e0, 8);
        enable = 1'b0;
        tick(2);

        // Enable dropped after the second strobe edge.
        r_x = 8'h3C;
        r_y = 8'hC3;
        r_btn = 2'b11;
        e0 = n_edges;
        v0 = n_valid;
        start_poll(c0);
        tick(9);
        enable = 1'b0;
        check("abort_edges_before", n_edges - e0, 2);
        s_hold = strobe_out;
        tick(60);
        check("abort_no_valid", n_valid, v0);
        check("abort_no_more_edges", n_edges - e0, 2);
        check("abort_strobe_held", {31'b0, strobe_out}, {31'b0, s_hold});
        check("abort_dx_kept", {24'b0, dx}, {24'b0, last_exp.dx});
        check("abort_dy_kept", {24'b0, dy}, {24'b0, last_exp.dy});
        check("abort_busy", {31'b0, busy}, 32'd0);
        exp_q.push_back(frame_t'({8'h3C, 8'hC3, 2'b00}));
        enable = 1'b1;
        e0 = cyc;
        wait_valid("realign_valid", v0 + 1, 260);
        check("realign_valid_time", last_valid_cyc, e0 + 225);
        enable = 1'b0;
        tick(2);

        // Reset during the settle of nibble 2.
        e0 = n_edges;
        start_poll(c0);
        tick(14);
        check("rst_mid_edges", n_edges - e0, 3);
        reset = 1'b1;
        tick(1);
        check("rst_mid_strobe", {31'b0, strobe_out}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_valid", {31'b0, valid}, 32'd0);
        check("rst_mid_dx", {24'b0, dx}, 32'd0);
        check("rst_mid_dy", {24'b0, dy}, 32'd0);
        reset = 1'b0;
        enable = 1'b0;
        tick(3);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msx_mouse_reader.md
Name: msx_mouse_reader

Overview:
- MSX-side initiator for the joystick-port mouse nibble protocol: toggles the port strobe, samples four 4-bit nibbles on the direction pins and assembles an X delta, a Y delta and two button bits.
- The opposite end of the core's mouse responder, which advances one nibble per strobe edge and resets its nibble index after an idle timeout of 100000 cycles.
- Used for loopback verification of the responder and for a native-mode port-B mouse reader in the emsx integration.

Parameters:
- SETTLE_CYC, 64: wait cycles after each strobe toggle before the nibble is sampled; minimum 1.
- POLL_CYC, 567500: automatic frame period in clk_sys cycles (20 ms at 28.375 MHz). Must exceed 100000 + 4*(SETTLE_CYC+2) so the responder re-aligns between frames.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = automatic polling and poll_now honoured
- poll_now  in  1  single-cycle request to start a frame immediately
- joy_in  in  6  port pins; [3:0] nibble data, [5:4] buttons, active low; asynchronous
- strobe_out  out  1  port strobe (pin 8)
- dx  out  8  X delta byte, raw two's complement as transmitted
- dy  out  8  Y delta byte, raw
- buttons  out  2  active-high buttons; [0] = ~joy_in[4], [1] = ~joy_in[5]
- valid  out  1  one-cycle pulse when dx/dy/buttons update
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset values: strobe_out=0, dx=0, dy=0, buttons=0, valid=0, busy=0, state IDLE, poll counter=0, nibble index=0. Synchronizer flops reset to 6'h3F.
- joy_in passes through a 2-flop synchronizer (joy_s). All sampling uses joy_s.
- Poll counter:
  - Increments every cycle in IDLE while enable=1.
  - At POLL_CYC-1 it wraps to 0 and starts a frame.
  - Held at 0 while enable=0 or busy=1.
- Frame start:
  - In IDLE with enable=1, either poll_now=1 or counter wrap starts a frame; both in the same cycle start exactly one frame.
  - poll_now while busy, or while enable=0, is ignored, not queued.
- State machine IDLE -> TOGGLE -> SETTLE -> SAMPLE -> (TOGGLE | DONE) -> IDLE:
  - TOGGLE: one cycle; strobe_out <= ~strobe_out; busy=1.
  - SETTLE: exactly SETTLE_CYC cycles via a down-counter of width $clog2(SETTLE_CYC+1).
  - SAMPLE: one cycle; nib[idx] <= joy_s[3:0]. If idx=3, also capture buttons <= ~joy_s[5:4]. If idx<3: idx++ and go to TOGGLE, else go to DONE.
  - DONE: one cycle; dx <= {nib0,nib1}, dy <= {nib2,nib3}, buttons register presented; valid=1; busy=0 from the next cycle; idx=0.
- Latency: frame-start cycle T. Strobe edges occur at T+1 + k*(SETTLE_CYC+2) for k=0..3. valid is asserted at T + 4*(SETTLE_CYC+2) + 1.
- Strobe is never forced back to a level. Four toggles per frame return it to its pre-frame level.
- dx/dy/buttons hold their values between valid pulses. No sign conversion and no accumulation are performed.
- enable deasserted mid-frame: abort at the next edge to IDLE, with no valid, dx/dy unchanged, and strobe_out held at its current level. The poll counter restarts from 0, so the responder times out before the next frame.
- reset mid-frame: all registers return to reset values immediately on the next edge, including strobe_out=0.

Test Plan:
- Loopback with responder latch x=+3 (transmits 8'hFD), y=8'h05, buttons idle, poll_now pulse, SETTLE_CYC=4 -> 4 strobe edges spaced 6 cycles apart, valid at T+25, dx=8'hFD, dy=8'h05, buttons=2'b00, strobe ends at its initial level.
- Static joy_in=6'b10_1010 (left button pressed), poll_now -> dx=8'hAA, dy=8'hAA, buttons=2'b01, exactly one valid pulse.
- enable=1, no poll_now, POLL_CYC=200 -> first frame starts at cycle 199 after reset release, then every 200 + frame length cycles; enable=0 -> no strobe edges for 1000 cycles.
- poll_now held high during a frame, then in the same cycle as counter wrap -> exactly one frame per request window and no back-to-back frames.
- enable dropped after the 2nd strobe edge -> no valid pulse, dx/dy retain prior values, strobe static. After re-enable and the responder timeout, the next frame returns correct bytes.
- reset asserted during SETTLE of nibble 2 -> the next cycle shows strobe_out=0, busy=0, valid=0, dx=dy=0.
